rf_write_queue: RTL and testbench

RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

---
 rtl/rf_wq_pkg.sv | 17 +
 rtl/rf_wq_fifo.sv | 56 +++++
 rtl/rf_write_queue.sv | 86 ++++++++
 tb/tb_rf_write_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wq_pkg.sv
// Shared types and sizing for the register-file write queue.
// Holds the entry layout and pointer-width helpers.
package rf_wq_pkg;

  localparam int WQ_DEPTH = 4;
  localparam int WQ_PTR_W = $clog2(WQ_DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wq_entry_t;

  function automatic int wq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_wq_fifo.sv
// Circular entry store with read/write pointers and occupancy count.
// Storage is not reset; validity comes only from pointers and count.
module rf_wq_fifo
  import rf_wq_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH,
  localparam int PW = wq_ptr_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  wq_entry_t              i_entry,
  output logic [PW:0]            o_count,
  output logic [PW-1:0]          o_rptr,
  output wq_entry_t [DEPTH-1:0]  o_mem
);

  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [PW:0]            r_count;
  wq_entry_t [DEPTH-1:0]  r_mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)
        r_wptr <= r_wptr + 1'b1;
      if (i_pop)
        r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_wptr] <= i_entry;
  end

  assign o_count = r_count;
  assign o_rptr  = r_rptr;
  assign o_mem   = r_mem;

endmodule

// File: rtl/rf_write_queue.sv
// Queues late writebacks and drains them into idle RF write slots.
// Also exposes forwarding of queued values and a pending-rd mask.
module rf_write_queue
  import rf_wq_pkg::*;
#(
  parameter int DEPTH = WQ_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_data,
  input  logic        pipe_wb_valid,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_din,
  input  logic [4:0]  fwd_rs,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic [31:0] pending_mask
);

  localparam int PW = wq_ptr_w(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW:0]           w_count;
  logic [PW-1:0]         w_rptr;
  wq_entry_t [DEPTH-1:0] w_mem;
  wq_entry_t             w_head;
  wq_entry_t             w_in;
  logic                  w_push;
  logic                  w_pop;
  logic [PW-1:0]         w_idx;
  logic                  w_hit;
  logic [31:0]           w_fdata;
  logic [31:0]           w_mask;

  // reset_n gates in_ready so it drops with the reset, not the next edge
  assign in_ready = reset_n && (w_count < FULL) && !flush;
  assign w_push   = in_valid && in_ready && (in_rd != 5'd0);
  assign w_pop    = (w_count != '0) && !pipe_wb_valid && !flush;
  assign w_in     = '{rd: in_rd, data: in_data};
  assign w_head   = w_mem[w_rptr];

  rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_in),
    .o_count (w_count),
    .o_rptr  (w_rptr),
    .o_mem   (w_mem)
  );

  assign wr_en  = w_pop;
  assign wr_rd  = w_pop ? w_head.rd   : 5'd0;
  assign wr_din = w_pop ? w_head.data : 32'd0;

  // walk oldest to youngest so the last match is the youngest
  always_comb begin
    w_idx   = '0;
    w_hit   = 1'b0;
    w_fdata = '0;
    w_mask  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rptr + PW'(k);
      if ((PW+1)'(k) < w_count) begin
        w_mask[w_mem[w_idx].rd] = 1'b1;
        if (fwd_rs != 5'd0 && w_mem[w_idx].rd == fwd_rs) begin
          w_hit   = 1'b1;
          w_fdata = w_mem[w_idx].data;
        end
      end
    end
    w_mask[0] = 1'b0;
  end

  assign fwd_hit      = w_hit;
  assign fwd_data     = w_fdata;
  assign pending_mask = w_mask;

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_rf_write_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        pipe_wb_valid;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_din;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [31:0] pending_mask;

  rf_write_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_data       (in_data),
    .pipe_wb_valid (pipe_wb_valid),
    .wr_en         (wr_en),
    .wr_rd         (wr_rd),
    .wr_din        (wr_din),
    .fwd_rs        (fwd_rs),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .pending_mask  (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_vec;
  int   n_err;
  logic e_rdy;
  logic e_pop;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic        hit;
    logic [31:0] fd;
    logic [31:0] mask;
    ent_t        h;
    hit  = 1'b0;
    fd   = '0;
    mask = '0;
    foreach (q[i]) begin
      mask[q[i].rd] = 1'b1;
      if (fwd_rs != 0 && q[i].rd == fwd_rs) begin
        hit = 1'b1;
        fd  = q[i].d;
      end
    end
    e_rdy = reset_n && (q.size() < DEPTH) && !flush;
    e_pop = (q.size() > 0) && !pipe_wb_valid && !flush;
    h.rd = 5'd0;
    h.d  = 32'd0;
    if (e_pop)
      h = q[0];
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("wr_en", 32'(wr_en), 32'(e_pop));
    chk("wr_rd", 32'(wr_rd), 32'(h.rd));
    chk("wr_din", wr_din, h.d);
    chk("fwd_hit", 32'(fwd_hit), 32'(hit));
    chk("fwd_data", fwd_data, fd);
    chk("pending_mask", pending_mask, mask);
  endtask

  task automatic probe();
    #3;
    check_all();
  endtask

  task automatic adv();
    ent_t e;
    @(posedge clk);
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      if (e_pop)
        void'(q.pop_front());
      if (in_valid && e_rdy && in_rd != 0) begin
        e.rd = in_rd;
        e.d  = in_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic step();
    probe();
    adv();
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] d);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_rd         = '0;
    in_data       = '0;
    pipe_wb_valid = 1'b0;
    fwd_rs        = '0;
    repeat (2) @(posedge clk);
    #1;
    probe();
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    probe();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    adv();

    // single write
    offer(5'd5, 32'hDEADBEEF);
    probe();
    chk("t35_ready", 32'(in_ready), 32'd1);
    adv();
    in_valid = 1'b0;
    probe();
    chk("t35_wen", 32'(wr_en), 32'd1);
    chk("t35_wrd", 32'(wr_rd), 32'd5);
    chk("t35_din", wr_din, 32'hDEADBEEF);
    adv();
    probe();
    chk("t35_mask5", 32'(pending_mask[5]), 32'd0);
    adv();

    // fill while pipeline owns the port, then drain in order
    pipe_wb_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(5'(i + 1), 32'h100 + 32'(i));
      step();
    end
    offer(5'd9, 32'h999);
    probe();
    chk("t36_full", 32'(in_ready), 32'd0);
    adv();
    in_valid      = 1'b0;
    pipe_wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      probe();
      chk("t36_order", 32'(wr_rd), 32'(i + 1));
      adv();
    end
    probe();
    chk("t36_empty", 32'(wr_en), 32'd0);
    adv();

    // forwarding picks the youngest
    pipe_wb_valid = 1'b1;
    offer(5'd7, 32'd1);
    step();
    offer(5'd7, 32'd2);
    step();
    in_valid = 1'b0;
    fwd_rs   = 5'd7;
    probe();
    chk("t37_hit", 32'(fwd_hit), 32'd1);
    chk("t37_data", fwd_data, 32'd2);
    chk("t37_mask", pending_mask, 32'h80);
    adv();
    pipe_wb_valid = 1'b0;
    step();
    step();

    // rd = 0 is swallowed
    offer(5'd0, 32'h1234);
    probe();
    chk("t38_ready", 32'(in_ready), 32'd1);
    adv();
    in_valid = 1'b0;
    probe();
    chk("t38_wen", 32'(wr_en), 32'd0);
    chk("t38_mask", pending_mask, 32'd0);
    adv();

    // flush beats a concurrent push
    pipe_wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(5'(10 + i), 32'hA0 + 32'(i));
      step();
    end
    flush = 1'b1;
    offer(5'd13, 32'hBB);
    probe();
    chk("t39_ready", 32'(in_ready), 32'd0);
    chk("t39_wen", 32'(wr_en), 32'd0);
    adv();
    flush         = 1'b0;
    in_valid      = 1'b0;
    pipe_wb_valid = 1'b0;
    probe();
    chk("t39_wen2", 32'(wr_en), 32'd0);
    chk("t39_mask", pending_mask, 32'd0);
    adv();

    // async reset mid-drain
    pipe_wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(5'(3 + i), 32'hC0 + 32'(i));
      step();
    end
    in_valid      = 1'b0;
    pipe_wb_valid = 1'b0;
    fwd_rs        = 5'd4;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t40_wen", 32'(wr_en), 32'd0);
    chk("t40_hit", 32'(fwd_hit), 32'd0);
    chk("t40_mask", pending_mask, 32'd0);
    chk("t40_ready", 32'(in_ready), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    probe();
    chk("t40_ready_rel", 32'(in_ready), 32'd1);
    adv();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      in_valid      = ($urandom_range(0, 99) < 60);
      in_rd         = ($urandom_range(0, 9) == 0) ? 5'd0
                      : 5'($urandom_range(1, 31));
      in_data       = $urandom;
      pipe_wb_valid = ($urandom_range(0, 99) < 45);
      flush         = ($urandom_range(0, 99) < 4);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        fwd_rs = q[$urandom_range(0, q.size() - 1)].rd;
      else
        fwd_rs = 5'($urandom_range(0, 31));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
